// File: rtl/freq_gate_counter_if.sv
// freq_gate_counter_if: signal-under-test inputs and measurement result bundle
interface freq_gate_counter_if;
    logic        sig_in;
    logic        meas_en;
    logic [27:0] freq;
    logic        freq_vld;
    logic        gate_active;
    logic        ovf;
    modport master (output sig_in, meas_en, input freq, freq_vld, gate_active, ovf);
    modport slave  (input sig_in, meas_en, output freq, freq_vld, gate_active, ovf);
endinterface

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts synchronised sig_in rises over a GATE_CYCLES window and publishes freq; FREQ_OVF_EN adds saturation and ovf
module freq_gate_counter #(
    parameter int unsigned GATE_CYCLES = 48_000_000,
    parameter int unsigned MAX_FREQ    = 99_999_999,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                sys_clk,
    input logic                sys_rst,
    freq_gate_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;
    localparam logic [31:0] LAST = GATE_CYCLES - 32'd1;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise;
    logic [31:0]            gate_cnt;
    logic [27:0]            edge_cnt;
    logic [27:0]            edge_nxt;
    logic [27:0]            freq_r;
    logic                   freq_vld_r;
    logic                   gate_r;
`ifdef FREQ_OVF_EN
    localparam logic [27:0] MAX_C = 28'(MAX_FREQ);
    logic                   ovf_r;
    assign edge_nxt = (rise && edge_cnt <= MAX_C) ? edge_cnt + 28'd1 : edge_cnt;
    assign bus.ovf  = ovf_r;
`else
    logic [31:0]            unused_max;
    assign unused_max = MAX_FREQ;
    assign edge_nxt   = edge_cnt + {27'd0, rise};
    assign bus.ovf    = 1'b0;
`endif
    assign rise            = sync[SYNC_STAGES-1] & ~hist;
    assign bus.freq        = freq_r;
    assign bus.freq_vld    = freq_vld_r;
    assign bus.gate_active = gate_r;
    // bring sig_in into the sys_clk domain and keep one cycle of history for edge detection
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            hist <= sync[SYNC_STAGES-1];
        end
    // measurement sequencer: open a gate window, latch the count for one cycle, abort when meas_en drops
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_r     <= '0;
            freq_vld_r <= 1'b0;
            gate_r     <= 1'b0;
`ifdef FREQ_OVF_EN
            ovf_r      <= 1'b0;
`endif
        end else begin
            freq_vld_r <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    gate_r   <= bus.meas_en;
                    state    <= bus.meas_en ? GATE : IDLE;
                end
                GATE: begin
                    if (!bus.meas_en) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        gate_r   <= 1'b0;
                    end else begin
                        edge_cnt <= edge_nxt;
                        gate_cnt <= gate_cnt + 32'd1;
                        if (gate_cnt == LAST) begin
                            state  <= LATCH;
                            gate_r <= 1'b0;
                        end
                    end
                end
                LATCH: begin
`ifdef FREQ_OVF_EN
                    freq_r   <= (edge_cnt > MAX_C) ? MAX_C : edge_cnt;
                    ovf_r    <= edge_cnt > MAX_C;
`else
                    freq_r   <= edge_cnt;
`endif
                    freq_vld_r <= 1'b1;
                    gate_cnt   <= '0;
                    edge_cnt   <= '0;
                    gate_r     <= bus.meas_en;
                    state      <= bus.meas_en ? GATE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: vector table, directed corner sequences and random stimulus against a window-level reference model
module tb_freq_gate_counter;
    localparam int G    = 100;
    localparam int MAXF = 20;
    localparam int S    = 2;
`ifdef FREQ_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    typedef struct {
        string name;
        int    mode;
        int    period;
        bit    lvl;
        int    exp_freq;
        bit    exp_ovf;
    } vec_t;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    freq_gate_counter_if bus();
    freq_gate_counter #(.GATE_CYCLES(G), .MAX_FREQ(MAXF), .SYNC_STAGES(S)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );
    always #5 sys_clk = ~sys_clk;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mode = 0;
    int period = 10;
    int ph = 0;
    bit lvl = 1'b0;
    always @(posedge sys_clk) cyc <= cyc + 1;
    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask
    // signal generator: DC level, square wave of `period` cycles, or random bits
    always @(posedge sys_clk) begin
        #2;
        ph = (ph + 1 >= period) ? 0 : ph + 1;
        if (mode == 0) bus.sig_in = lvl;
        else if (mode == 1) bus.sig_in = (ph < period / 2);
        else bus.sig_in = 1'($urandom_range(0, 1));
    end
    // reference model: rises seen S+1 cycles late, windows of G cycles, one latch cycle, unbounded count
    int samp[S+2];
    int wpos = -1;
    int cnt = 0;
    longint m_freq = 0;
    bit m_vld = 0, m_gate = 0, m_ovf = 0;
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            foreach (samp[i]) samp[i] = 0;
            wpos = -1; cnt = 0; m_freq = 0; m_vld = 0; m_ovf = 0;
        end else begin
            for (int i = S + 1; i > 0; i--) samp[i] = samp[i-1];
            samp[0] = int'(bus.sig_in);
            m_vld = 0;
            if (wpos < 0) begin
                if (bus.meas_en) wpos = 0;
            end else if (wpos < G) begin
                if (!bus.meas_en) begin
                    wpos = -1; cnt = 0;
                end else begin
                    cnt += (samp[S] == 1 && samp[S+1] == 0) ? 1 : 0;
                    wpos++;
                end
            end else begin
                if (OVF) begin
                    m_ovf  = cnt > MAXF;
                    m_freq = (cnt > MAXF) ? MAXF : cnt;
                end else begin
                    m_ovf  = 0;
                    m_freq = cnt % (1 << 28);
                end
                m_vld = 1; cnt = 0;
                wpos = bus.meas_en ? 0 : -1;
            end
        end
        m_gate = (wpos >= 0 && wpos < G);
    end
    // continuous comparison of every output against the model, away from the clock edge
    always @(negedge sys_clk) begin
        check("m_freq", bus.freq, sys_rst ? 0 : m_freq);
        check("m_vld", bus.freq_vld, sys_rst ? 0 : m_vld);
        check("m_gate", bus.gate_active, sys_rst ? 0 : m_gate);
        check("m_ovf", bus.ovf, sys_rst ? 0 : m_ovf);
    end
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask
    task automatic wait_vld(output int t);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.freq_vld && n < 400);
        check("vld_seen", bus.freq_vld, 1);
        t = cyc;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    vec_t tbl[7];
    initial begin
        int t1, t2, nv;
        tbl[0] = '{"nominal",   1, 10, 1'b0, 10, 1'b0};
        tbl[1] = '{"dc_low",    0, 10, 1'b0, 0,  1'b0};
        tbl[2] = '{"dc_high",   0, 10, 1'b1, 0,  1'b0};
        tbl[3] = '{"ovf_p2",    1, 2,  1'b0, OVF ? 20 : 50, OVF};
        tbl[4] = '{"after_ovf", 1, 10, 1'b0, 10, 1'b0};
        tbl[5] = '{"at_max_p5", 1, 5,  1'b0, 20, 1'b0};
        tbl[6] = '{"ovf_p4",    1, 4,  1'b0, OVF ? 20 : 25, OVF};
        bus.sig_in = 1'b0;
        bus.meas_en = 1'b1;
        sys_rst = 1'b1;
        mode = 2;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            check("rst_freq", bus.freq, 0);
            check("rst_vld", bus.freq_vld, 0);
            check("rst_gate", bus.gate_active, 0);
            check("rst_ovf", bus.ovf, 0);
        end
        tick();
        sys_rst = 1'b0;
        bus.meas_en = 1'b0;
        foreach (tbl[v]) begin
            bus.meas_en = 1'b0;
            mode = tbl[v].mode;
            period = tbl[v].period;
            lvl = tbl[v].lvl;
            repeat (15) tick();
            bus.meas_en = 1'b1;
            wait_vld(t1);
            @(negedge sys_clk);
            check({tbl[v].name, "_vld_width"}, bus.freq_vld, 0);
            wait_vld(t2);
            check({tbl[v].name, "_spacing"}, t2 - t1, G + 1);
            check({tbl[v].name, "_freq"}, bus.freq, tbl[v].exp_freq);
            check({tbl[v].name, "_ovf"}, bus.ovf, tbl[v].exp_ovf);
        end
        bus.meas_en = 1'b0;
        mode = 0;
        lvl = 1'b0;
        repeat (10) tick();
        bus.meas_en = 1'b1;
        for (int r = 0; r <= 303; r++) begin
            tick();
            lvl = (r == 8 || r == 97 || r == 149 || r == 199);
            @(negedge sys_clk);
            if (r == 99)  check("bnd_gate_last", bus.gate_active, 1);
            if (r == 100) check("bnd_gate_latch", bus.gate_active, 0);
            if (r == 101) check("bnd_w1_freq", bus.freq, 2);
            if (r == 202) check("bnd_w2_freq", bus.freq, 1);
            if (r == 303) check("bnd_w3_freq", bus.freq, 0);
            if (r == 101 || r == 202 || r == 303) check("bnd_vld", bus.freq_vld, 1);
        end
        bus.meas_en = 1'b0;
        mode = 1;
        period = 10;
        repeat (15) tick();
        bus.meas_en = 1'b1;
        for (int r = 0; r <= 151; r++) begin
            tick();
            if (r == 151) bus.meas_en = 1'b0;
            @(negedge sys_clk);
            if (r == 101) check("abort_w1_vld", bus.freq_vld, 1);
            if (r == 101) check("abort_w1_freq", bus.freq, 10);
            if (r == 151) check("abort_gate_hold", bus.gate_active, 1);
        end
        tick();
        @(negedge sys_clk);
        check("abort_gate_off", bus.gate_active, 0);
        nv = 0;
        for (int r = 0; r < 300; r++) begin
            @(negedge sys_clk);
            nv += int'(bus.freq_vld);
        end
        check("abort_no_vld", nv, 0);
        check("abort_freq_hold", bus.freq, 10);
        tick();
        bus.meas_en = 1'b1;
        for (int r = 0; r <= 101; r++) begin
            tick();
            @(negedge sys_clk);
            if (r == 0)   check("restart_gate", bus.gate_active, 1);
            if (r == 100) check("restart_early_vld", bus.freq_vld, 0);
            if (r == 101) check("restart_vld", bus.freq_vld, 1);
            if (r == 101) check("restart_freq", bus.freq, 10);
        end
        mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                mode = int'($urandom_range(1, 2));
                period = int'($urandom_range(2, 12));
            end
            if (sys_rst) sys_rst = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 999) == 0) sys_rst = 1'b1;
            if (bus.meas_en) begin
                if ($urandom_range(0, 399) == 0) bus.meas_en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) bus.meas_en = 1'b1;
        end
        sys_rst = 1'b0;
        repeat (2) tick();
        @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Measurement front end of the frequency meter: synchronises the external test signal, counts its rising edges over a fixed gate window of system clocks, and publishes the count as `freq[27:0]`.
- `freq[27:0]` feeds the 8-digit seven-segment display stage directly downstream.
- Result is in Hz when the gate is 1 s.
- Continuous back-to-back measurements while enabled.

Parameters:
- GATE_CYCLES, 48_000_000, gate window length in sys_clk cycles (1 s at 48 MHz); legal range 2..2^32-1.
- MAX_FREQ, 99_999_999, largest count the display can show (8 digits); saturation limit.
- SYNC_STAGES, 2, flip-flop stages in the sig_in synchroniser; minimum 2.

Ports:
- sys_clk  in  1  system clock, 48 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- sig_in  in  1  external signal under test, asynchronous to sys_clk.
- meas_en  in  1  1 = run measurements continuously; 0 = stop/abort.
- freq  out  28  last completed count; held between updates.
- freq_vld  out  1  one-cycle pulse when freq is updated.
- gate_active  out  1  high while a gate window is open.
- ovf  out  1  last completed count exceeded MAX_FREQ (see Optional Feature).

Behaviour:
- Reset: one clock (sys_clk); reset (sys_rst) is asynchronous, active-high. All of the following clear immediately:
  - freq=0, freq_vld=0, gate_active=0, ovf=0.
  - Synchroniser, edge register, gate counter and edge counter = 0.
  - State = IDLE.
- Synchroniser and edge detect:
  - sig_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~hist.
  - A sig_in rising edge is detected SYNC_STAGES+1 cycles later.
  - Maximum countable input frequency is sys_clk/2. High and low phases shorter than one clock may be lost; this is accepted.
- State machine (IDLE, GATE, LATCH):
  - IDLE:
    - gate_active=0; counters held at 0.
    - meas_en=1 → GATE on the next cycle.
  - GATE:
    - gate_active=1.
    - Gate counter increments every cycle from 0.
    - Edge counter increments on each rise.
    - When the gate counter equals GATE_CYCLES-1, that cycle's rise is still counted, and the next state is LATCH.
    - The window is exactly GATE_CYCLES cycles.
  - LATCH (exactly one cycle):
    - freq <= edge count (saturated or wrapped per Optional Feature); freq_vld=1 for this cycle only; ovf updated.
    - Both counters cleared. A rise in this cycle is discarded (one-cycle dead time per measurement).
    - Next state: GATE if meas_en=1, else IDLE.
  - Measurement period while enabled = GATE_CYCLES+1 cycles.
- meas_en falling during GATE:
  - Abort to IDLE on the next cycle; counters cleared.
  - No freq_vld; freq and ovf hold their previous values.
  - meas_en falling during LATCH: the latch completes normally, then IDLE.
- Arithmetic:
  - Gate counter: 32 bit.
  - Edge counter: 28 bit, must never silently wrap when FREQ_OVF_EN is defined.
  - freq is output directly from a register; no combinational path from sig_in.
- Reset asserted mid-GATE or mid-LATCH:
  - Immediate return to the reset state; any pending result is dropped.
  - After release, measurement restarts from IDLE.

Optional Feature:
- Macro: FREQ_OVF_EN.
- Defined:
  - Edge counter saturates at MAX_FREQ+1.
  - At LATCH: if count > MAX_FREQ, then freq <= MAX_FREQ and ovf <= 1; else freq <= count and ovf <= 0.
  - Downstream shows 99999999 on overflow.
- Not defined:
  - No comparison logic.
  - Edge counter wraps modulo 2^28; freq <= count.
  - ovf is tied to 0.

Test Plan:
- Reset hold: sys_rst=1 with sig_in toggling and meas_en=1 → freq=0, freq_vld=0, gate_active=0, ovf=0 throughout.
- Nominal count (GATE_CYCLES=100): meas_en=1, sig_in square wave of period 10 cycles, started before enable → exactly 10 counted edges; each freq_vld pulse is 1 cycle wide and shows freq=10; pulses are 101 cycles apart.
- DC input: sig_in held 0, then held 1 for a full window → freq=0 with freq_vld pulsed; ovf=0.
- Boundary edge (GATE_CYCLES=100): place a detected rise on gate cycle 99 and another on the LATCH cycle → the first is counted, the second is not; freq equals the in-window count.
- Abort: drop meas_en at gate cycle 50 of the second window → no further freq_vld; freq holds the first result; gate_active=0 from the next cycle. Re-raising meas_en gives a fresh full window.
- Overflow (GATE_CYCLES=100, MAX_FREQ=20, sig_in period 2 = 50 edges):
  - FREQ_OVF_EN defined → freq=20, ovf=1.
  - Not defined → freq=50, ovf=0.
  - Then with period 10 and the macro defined → freq=10, ovf=0.
